// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike fetch path.
// The fetch-halt state type is only used when RISC_V_MIKE_FETCH_HALT_ON_ZERO_EN is defined.
package risc_v_mike_pkg;

  localparam int PC_W      = 32;
  localparam int DATA_32_W = 32;

  typedef logic [PC_W-1:0] t_pc_addr;

  localparam t_pc_addr PC_INCR        = t_pc_addr'(4);
  localparam t_pc_addr FETCH_RESET_PC = '0;

  typedef struct packed {
    t_pc_addr               pc;
    logic [DATA_32_W-1:0]   instr;
  } t_fetch_entry;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } t_fetch_state;

endpackage

// File: rtl/risc_v_mike_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs with flush; the head is read combinationally
// so decode sees an entry the cycle after it was written. Reads as zero when empty.
module risc_v_mike_fetch_fifo
  import risc_v_mike_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  t_fetch_entry               wr_entry,
  output t_fetch_entry               head_entry,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  t_fetch_entry     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!push && pop)
      count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= wr_entry;
  end

  assign head_entry = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction-fetch unit: owns the PC, buffers fetched {pc, instr} toward decode, handles redirect.
// Define RISC_V_MIKE_FETCH_HALT_ON_ZERO_EN to stop fetching on an all-zero instruction word.
module risc_v_mike_fetch_unit
  import risc_v_mike_pkg::*;
#(
  parameter int       FETCH_FIFO_DEPTH = 4,
  parameter t_pc_addr RESET_PC         = FETCH_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  output t_pc_addr             imem_addr,
  input  logic [DATA_32_W-1:0] imem_rd_data,
  input  logic                 redirect_valid,
  input  t_pc_addr             redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [DATA_32_W-1:0] instr_data,
  output t_pc_addr             instr_pc,
  output logic                 misalign_err,
  output logic                 fetch_halted
);

  localparam int CNT_W = $clog2(FETCH_FIFO_DEPTH+1);

  t_pc_addr     pc_reg, pc_next;
  logic         misalign_reg;
  logic [CNT_W-1:0] count;
  t_fetch_entry wr_entry, head_entry;
  logic         pop, fetch_ok, push;

  assign imem_addr   = pc_reg;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready & ~redirect_valid;
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign fetch_ok    = ~redirect_valid & ~fetch_halted &
                       ((count < CNT_W'(FETCH_FIFO_DEPTH)) | pop);

`ifdef RISC_V_MIKE_FETCH_HALT_ON_ZERO_EN
  t_fetch_state state_reg, state_next;
  logic         halt_hit;

  assign halt_hit = fetch_ok & (imem_rd_data == '0);
  assign push     = fetch_ok & ~halt_hit;

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= FETCH_RUN;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid)
      state_next = FETCH_RUN;
    else if (state_reg == FETCH_RUN && halt_hit)
      state_next = FETCH_HALT;
  end

  assign fetch_halted = (state_reg == FETCH_HALT);
`else
  assign push         = fetch_ok;
  assign fetch_halted = 1'b0;
`endif

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid)
      pc_next = {redirect_pc[PC_W-1:2], 2'b00};
    else if (push)
      pc_next = pc_reg + PC_INCR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      misalign_reg <= redirect_valid & (|redirect_pc[1:0]);
    end
  end

  assign wr_entry.pc    = pc_reg;
  assign wr_entry.instr = imem_rd_data;

  risc_v_mike_fetch_fifo #(
    .DEPTH (FETCH_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  assign instr_data   = head_entry.instr;
  assign instr_pc     = head_entry.pc;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Directed bench for risc_v_mike_fetch_unit: memory word at byte address a is (a>>2)+1,
// optionally zero at 0x14. Inputs change and outputs are sampled on the falling edge.
module tb_risc_v_mike_fetch_unit;
  import risc_v_mike_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  t_pc_addr             imem_addr;
  logic [DATA_32_W-1:0] imem_rd_data;
  logic                 redirect_valid;
  t_pc_addr             redirect_pc;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [DATA_32_W-1:0] instr_data;
  t_pc_addr             instr_pc;
  logic                 misalign_err;
  logic                 fetch_halted;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  logic zero_en    = 1'b0;

  always #5 clk = ~clk;

  assign imem_rd_data = (zero_en && imem_addr == 32'h14) ? 32'h0 : (imem_addr >> 2) + 32'd1;

  risc_v_mike_fetch_unit #(
    .FETCH_FIFO_DEPTH (4),
    .RESET_PC         (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err),
    .fetch_halted   (fetch_halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s %h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
    check_val({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_val({tag, "_pc"}, instr_pc, pc);
    check_val({tag, "_data"}, instr_data, data);
  endtask

  // Redirect for one cycle; returns on the falling edge after the redirect edge.
  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    tick();
    tick();
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_data", instr_data, 32'h0);
    check_val("rst_pc", instr_pc, 32'h0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("rst_misalign", 32'(misalign_err), 32'd0);
    check_val("rst_halted", 32'(fetch_halted), 32'd0);

    // Streaming one instruction per cycle
    rst         = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head("stream", 32'(4 * i), 32'(i + 1));
    end

    // Back-pressure fills the buffer and stalls the PC
    instr_ready = 1'b0;
    redir(32'h0);
    check_val("flush_valid", 32'(instr_valid), 32'd0);
    repeat (10) tick();
    check_val("stall_addr", imem_addr, 32'h10);
    check_head("stall_head", 32'h0, 32'h1);

    // Full with pop: push and pop together, sequence continues without gaps
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_head("fullpop", 32'(4 * i), 32'(i + 1));
      check_val("fullpop_addr", imem_addr, 32'(32'h10 + 4 * i));
      tick();
    end

    // Redirect with three entries buffered
    instr_ready = 1'b0;
    redir(32'h0);
    repeat (3) tick();
    check_val("three_addr", imem_addr, 32'hC);
    check_val("three_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    redir(32'h40);
    check_val("redir_valid", 32'(instr_valid), 32'd0);
    check_val("redir_addr", imem_addr, 32'h40);
    check_val("redir_misalign", 32'(misalign_err), 32'd0);
    tick();
    check_head("redir_head", 32'h40, 32'h11);
    redir(32'h42);
    check_val("mis_pulse", 32'(misalign_err), 32'd1);
    check_val("mis_valid", 32'(instr_valid), 32'd0);
    check_val("mis_addr", imem_addr, 32'h40);
    tick();
    check_val("mis_clear", 32'(misalign_err), 32'd0);
    check_head("mis_head", 32'h40, 32'h11);

    // PC wrap at the top of the address space
    redir(32'hFFFF_FFFC);
    check_val("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_head("wrap_top", 32'hFFFF_FFFC, 32'h4000_0000);
    check_val("wrap_addr1", imem_addr, 32'h0);
    tick();
    check_head("wrap_zero", 32'h0, 32'h1);

    // Zero instruction word at 0x14
    zero_en = 1'b1;
    redir(32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_head("zero_drain", 32'(4 * k), 32'(k + 1));
    end
`ifdef RISC_V_MIKE_FETCH_HALT_ON_ZERO_EN
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("halt_valid", 32'(instr_valid), 32'd0);
      check_val("halt_flag", 32'(fetch_halted), 32'd1);
      check_val("halt_addr", imem_addr, 32'h14);
    end
    redir(32'h0);
    check_val("halt_clear", 32'(fetch_halted), 32'd0);
    tick();
    check_head("halt_resume", 32'h0, 32'h1);
`else
    tick();
    check_head("zero_word", 32'h14, 32'h0);
    check_val("zero_halted", 32'(fetch_halted), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
